// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - program counter with next-PC selection and circular return-address stack
module pc_unit #(
  parameter int                WIDTH        = 64,
  parameter logic [WIDTH-1:0]  RESET_VECTOR = '0,
  parameter logic [WIDTH-1:0]  TRAP_VECTOR  = 'h100,
  parameter int                STEP         = 4,
  parameter int                RAS_DEPTH    = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         trap,
  input  logic                         redirect_valid,
  input  logic [WIDTH-1:0]             redirect_target,
  input  logic                         call,
  input  logic                         ret,
  output logic [WIDTH-1:0]             pc,
  output logic [WIDTH-1:0]             pc_plus_step,
  output logic [$clog2(RAS_DEPTH):0]   ras_count,
  output logic                         ras_empty,
  output logic                         ras_full,
  output logic                         misalign_err,
  output logic                         underflow_err
);

  localparam int               PW       = $clog2(RAS_DEPTH);
  localparam int               CW       = PW + 1;
  localparam logic [WIDTH-1:0] STEP_W   = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] LOW_MASK = STEP_W - 1'b1;
  localparam logic [CW-1:0]    DEPTH_C  = CW'(RAS_DEPTH);

  logic [WIDTH-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0]    top;
  logic [WIDTH-1:0] pc_next;
  logic [WIDTH-1:0] aligned_target;
  logic             do_push;
  logic             do_pop;
  logic             do_replace;
  logic             do_redirect;
  logic             do_underflow;
  logic             ras_write;
  logic [PW-1:0]    ras_wr_idx;

  assign pc_plus_step   = pc + STEP_W;
  assign aligned_target = redirect_target & ~LOW_MASK;
  assign ras_empty      = (ras_count == '0);
  assign ras_full       = (ras_count == DEPTH_C);

  // Next-PC selection in priority order: trap, stall, call+ret, ret, redirect/call, increment.
  always_comb begin
    pc_next      = pc_plus_step;
    do_push      = 1'b0;
    do_pop       = 1'b0;
    do_replace   = 1'b0;
    do_redirect  = 1'b0;
    do_underflow = 1'b0;
    if (trap) begin
      pc_next = TRAP_VECTOR;
    end else if (stall) begin
      pc_next = pc;
    end else if (ret && call && redirect_valid) begin
      pc_next     = aligned_target;
      do_redirect = 1'b1;
      if (ras_empty) begin
        do_push = 1'b1;
      end else begin
        do_replace = 1'b1;
      end
    end else if (ret) begin
      if (ras_empty) begin
        do_underflow = 1'b1;
      end else begin
        do_pop  = 1'b1;
        pc_next = ras_mem[top];
      end
    end else if (redirect_valid) begin
      pc_next     = aligned_target;
      do_redirect = 1'b1;
      do_push     = call;
    end
  end

  always_comb begin
    ras_write  = !reset && (do_push || do_replace);
    ras_wr_idx = do_push ? top + PW'(1) : top;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc            <= RESET_VECTOR;
      top           <= '0;
      ras_count     <= '0;
      misalign_err  <= 1'b0;
      underflow_err <= 1'b0;
    end else begin
      pc            <= pc_next;
      misalign_err  <= do_redirect && ((redirect_target & LOW_MASK) != '0);
      underflow_err <= do_underflow;
      if (do_push) begin
        top <= top + PW'(1);
        // A push into a full stack overwrites the oldest entry, so the count saturates.
        if (!ras_full) begin
          ras_count <= ras_count + CW'(1);
        end
      end else if (do_pop) begin
        top       <= top - PW'(1);
        ras_count <= ras_count - CW'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (ras_write) begin
      ras_mem[ras_wr_idx] <= pc_plus_step;
    end
  end

endmodule
